// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the single-port memory.
// The arbiter connects through the slave modport; requesters and memory use the master side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_valid;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for a single-port memory with fixed read latency; data path has priority.
// Define ARB_STARVE_GUARD_EN to force a waiting fetch through after STARVE_LIMIT data grants.
//
// state | meaning
// IDLE  | sample requests, capture selected address/we/wdata
// ISSUE | one-cycle mem_en strobe and grant pulse
// WAIT  | remaining MEM_LAT-1 latency cycles (skipped when MEM_LAT=1)
// RESP  | one-cycle valid pulse to the granted requester
module mem_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  mem_port_arbiter_if.slave bus,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT > 1 ? MEM_LAT - 2 : 0);

  generate
    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
      $error("mem_port_arbiter: MEM_LAT must be 1..15");
    end
    if (STARVE_LIMIT < 1) begin : g_bad_starve
      $error("mem_port_arbiter: STARVE_LIMIT must be >= 1");
    end
  endgenerate

  state_t            state, state_nxt;
  logic              pick_dm, pick_if, force_if;
  logic              sel_dm, we_r;
  logic [3:0]        lat_cnt;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r, if_rd_r, dm_rd_r;

  assign pick_dm = bus.dm_req && !force_if;
  assign pick_if = bus.if_req && !pick_dm;

`ifdef ARB_STARVE_GUARD_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  logic [SC_W-1:0] starve_cnt;

  // Only data grants that overtake a waiting fetch count toward starvation.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (pick_if)
        starve_cnt <= '0;
      else if (pick_dm && bus.if_req)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign force_if = bus.if_req && (starve_cnt >= SC_W'(STARVE_LIMIT));
`else
  assign force_if = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_dm || pick_if) state_nxt = ISSUE;
      ISSUE:   state_nxt = (MEM_LAT > 1) ? WAIT : RESP;
      WAIT:    if (lat_cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_en   = 1'b0;
    bus.mem_we   = 1'b0;
    bus.if_gnt   = 1'b0;
    bus.dm_gnt   = 1'b0;
    bus.if_valid = 1'b0;
    bus.dm_valid = 1'b0;
    busy         = (state != IDLE);
    case (state)
      ISSUE: begin
        bus.mem_en = 1'b1;
        bus.mem_we = we_r;
        bus.if_gnt = !sel_dm;
        bus.dm_gnt = sel_dm;
      end
      RESP: begin
        bus.if_valid = !sel_dm;
        bus.dm_valid = sel_dm;
      end
      default: ;
    endcase
  end

  // Read data is latched on the edge entering RESP so it lines up with the valid pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sel_dm  <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      lat_cnt <= '0;
      if_rd_r <= '0;
      dm_rd_r <= '0;
    end else begin
      if (state == IDLE && (pick_dm || pick_if)) begin
        sel_dm <= pick_dm;
        we_r   <= pick_dm && bus.dm_we;
        addr_r <= pick_dm ? bus.dm_addr : bus.if_addr;
        if (pick_dm) wdata_r <= bus.dm_wdata;
      end
      if (state == ISSUE)
        lat_cnt <= LAT_LOAD;
      else if (state == WAIT && lat_cnt != 4'd0)
        lat_cnt <= lat_cnt - 1'b1;
      if (state_nxt == RESP && !we_r) begin
        if (sel_dm) dm_rd_r <= bus.mem_rdata;
        else        if_rd_r <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_addr  = addr_r;
  assign bus.mem_wdata = wdata_r;
  assign bus.if_rdata  = if_rd_r;
  assign bus.dm_rdata  = dm_rd_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: MEM_LAT=2 instance for most scenarios, MEM_LAT=1 for the burst.
// Honours ARB_STARVE_GUARD_EN when choosing the expected starvation outcome.
module tb_mem_port_arbiter;
  localparam int LAT_A = 2;
  localparam int STARVE = 4;

  logic clk, rst_n, busy_a, busy_b;
  int tests = 0;
  int fails = 0;
  logic [15:0] exp_if_q[$];
  logic [15:0] exp_dm_q[$];
  logic [15:0] dm_rd_model;

  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) b2 ();
  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) b1 ();

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT_A), .STARVE_LIMIT(STARVE)) dut_a (
    .clock(clk), .reset(rst_n), .bus(b2.slave), .busy(busy_a));
  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1), .STARVE_LIMIT(STARVE)) dut_b (
    .clock(clk), .reset(rst_n), .bus(b1.slave), .busy(busy_b));

  function automatic logic [15:0] mem_model(input logic [15:0] a);
    return (a == 16'h0010) ? 16'h1234 : (a ^ 16'hC3A5);
  endfunction

  // Memory read data follows the held address, so it is stable for the whole transaction.
  assign b2.mem_rdata = mem_model(b2.mem_addr);
  assign b1.mem_rdata = mem_model(b1.mem_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic wait_valid(input int limit, output int cyc);
    cyc = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      cyc++;
      if (b2.if_valid || b2.dm_valid) return;
    end
    cyc = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    tests++;
    if ({b2.if_gnt, b2.if_valid, b2.dm_gnt, b2.dm_valid, b2.mem_en, b2.mem_we, busy_a} !== 7'b0) begin
      fails++;
      $display("FAIL reset_ctrl got %b want 0000000",
               {b2.if_gnt, b2.if_valid, b2.dm_gnt, b2.dm_valid, b2.mem_en, b2.mem_we, busy_a});
    end
    tests++;
    if ({b2.mem_addr, b2.mem_wdata, b2.if_rdata, b2.dm_rdata} !== 64'h0) begin
      fails++;
      $display("FAIL reset_data got %h want 0", {b2.mem_addr, b2.mem_wdata, b2.if_rdata, b2.dm_rdata});
    end
    dm_rd_model = 16'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fetch();
    int cyc;
    logic [15:0] exp;
    @(posedge clk); #1;
    b2.if_req = 1'b1; b2.if_addr = 16'h0010;
    exp_if_q.push_back(mem_model(16'h0010));
    @(negedge clk); @(negedge clk);
    tests++;
    if ({b2.if_gnt, b2.mem_en, b2.mem_we, b2.dm_gnt} !== 4'b1100 || b2.mem_addr !== 16'h0010) begin
      fails++;
      $display("FAIL fetch_issue got gnt/en/we/dgnt=%b addr=%h want 1100 0010",
               {b2.if_gnt, b2.mem_en, b2.mem_we, b2.dm_gnt}, b2.mem_addr);
    end
    @(posedge clk); #1;
    b2.if_req = 1'b0;
    wait_valid(20, cyc);
    tests++;
    if (cyc !== LAT_A) begin
      fails++;
      $display("FAIL fetch_latency got %0d want %0d", cyc, LAT_A);
    end
    exp = (exp_if_q.size() > 0) ? exp_if_q.pop_front() : 16'hxxxx;
    tests++;
    if (b2.if_valid !== 1'b1 || b2.dm_valid !== 1'b0 || b2.if_rdata !== exp) begin
      fails++;
      $display("FAIL fetch_data got v=%b dv=%b rdata=%h want 1 0 %h", b2.if_valid, b2.dm_valid, b2.if_rdata, exp);
    end
    tests++;
    if (b2.dm_rdata !== dm_rd_model) begin
      fails++;
      $display("FAIL fetch_dm_hold got %h want %h", b2.dm_rdata, dm_rd_model);
    end
    @(negedge clk);
    tests++;
    if (busy_a !== 1'b0 || b2.if_valid !== 1'b0) begin
      fails++;
      $display("FAIL fetch_idle got busy=%b valid=%b want 0 0", busy_a, b2.if_valid);
    end
  endtask

  task automatic test_write();
    int cyc;
    logic [15:0] exp;
    @(posedge clk); #1;
    b2.dm_req = 1'b1; b2.dm_we = 1'b1; b2.dm_addr = 16'h0020; b2.dm_wdata = 16'hAAAA;
    exp_dm_q.push_back(dm_rd_model);
    @(negedge clk); @(negedge clk);
    tests++;
    if ({b2.dm_gnt, b2.mem_en, b2.mem_we, b2.if_gnt} !== 4'b1110 ||
        b2.mem_addr !== 16'h0020 || b2.mem_wdata !== 16'hAAAA) begin
      fails++;
      $display("FAIL write_issue got %b %h/%h want 1110 0020/aaaa",
               {b2.dm_gnt, b2.mem_en, b2.mem_we, b2.if_gnt}, b2.mem_addr, b2.mem_wdata);
    end
    @(posedge clk); #1;
    b2.dm_req = 1'b0; b2.dm_we = 1'b0;
    wait_valid(20, cyc);
    exp = (exp_dm_q.size() > 0) ? exp_dm_q.pop_front() : 16'hxxxx;
    tests++;
    if (cyc !== LAT_A || b2.dm_valid !== 1'b1 || b2.if_valid !== 1'b0 || b2.dm_rdata !== exp) begin
      fails++;
      $display("FAIL write_resp got cyc=%0d dv=%b iv=%b rdata=%h want %0d 1 0 %h",
               cyc, b2.dm_valid, b2.if_valid, b2.dm_rdata, LAT_A, exp);
    end
  endtask

  task automatic test_simultaneous();
    int en_t[$];
    int dm_g = -1, if_g = -1, dv = -1, iv = -1;
    logic s_dg, s_ig;
    logic [15:0] exp;
    @(posedge clk); #1;
    b2.dm_req = 1'b1; b2.dm_we = 1'b0; b2.dm_addr = 16'h0030;
    b2.if_req = 1'b1; b2.if_addr = 16'h0040;
    exp_dm_q.push_back(mem_model(16'h0030));
    exp_if_q.push_back(mem_model(16'h0040));
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      s_dg = b2.dm_gnt; s_ig = b2.if_gnt;
      if (b2.mem_en) en_t.push_back(c);
      if (s_dg && dm_g < 0) dm_g = c;
      if (s_ig && if_g < 0) if_g = c;
      tests++;
      if (b2.dm_valid && b2.if_valid) begin
        fails++;
        $display("FAIL sim_both_valid at cycle %0d got 11 want one-hot", c);
      end
      if (b2.dm_valid) begin
        dv = c;
        exp = (exp_dm_q.size() > 0) ? exp_dm_q.pop_front() : 16'hxxxx;
        dm_rd_model = exp;
        tests++;
        if (b2.dm_rdata !== exp) begin
          fails++;
          $display("FAIL sim_dm_rdata got %h want %h", b2.dm_rdata, exp);
        end
      end
      if (b2.if_valid) begin
        iv = c;
        exp = (exp_if_q.size() > 0) ? exp_if_q.pop_front() : 16'hxxxx;
        tests++;
        if (b2.if_rdata !== exp) begin
          fails++;
          $display("FAIL sim_if_rdata got %h want %h", b2.if_rdata, exp);
        end
      end
      @(posedge clk); #1;
      if (s_dg) b2.dm_req = 1'b0;
      if (s_ig) b2.if_req = 1'b0;
    end
    tests++;
    if (!(dm_g >= 0 && if_g > dm_g)) begin
      fails++;
      $display("FAIL sim_order got dm_gnt@%0d if_gnt@%0d want data first", dm_g, if_g);
    end
    tests++;
    if (if_g !== dv + 2) begin
      fails++;
      $display("FAIL sim_fetch_after got if_gnt@%0d want %0d", if_g, dv + 2);
    end
    tests++;
    if (en_t.size() !== 2 || en_t[1] - en_t[0] !== LAT_A + 2) begin
      fails++;
      $display("FAIL sim_en_spacing got %0d pulses want 2 pulses %0d apart", en_t.size(), LAT_A + 2);
    end
    tests++;
    if (iv !== if_g + LAT_A) begin
      fails++;
      $display("FAIL sim_if_latency got valid@%0d want %0d", iv, if_g + LAT_A);
    end
  endtask

  task automatic test_starvation();
    int grants = 0, valids = 0, first_if = 0, exp_first;
    logic [15:0] exp;
`ifdef ARB_STARVE_GUARD_EN
    exp_first = STARVE + 1;
`else
    exp_first = 0;
`endif
    @(posedge clk); #1;
    b2.dm_req = 1'b1; b2.dm_we = 1'b0; b2.dm_addr = 16'h0050;
    b2.if_req = 1'b1; b2.if_addr = 16'h0058;
    for (int c = 0; c < 80 && valids < 6; c++) begin
      @(negedge clk);
      if (b2.dm_gnt || b2.if_gnt) grants++;
      if (b2.if_gnt && first_if == 0) first_if = grants;
      if (b2.dm_gnt) exp_dm_q.push_back(mem_model(16'h0050));
      if (b2.if_gnt) exp_if_q.push_back(mem_model(16'h0058));
      if (b2.dm_valid) begin
        valids++;
        exp = (exp_dm_q.size() > 0) ? exp_dm_q.pop_front() : 16'hxxxx;
        dm_rd_model = exp;
        tests++;
        if (b2.dm_rdata !== exp) begin
          fails++;
          $display("FAIL starve_dm_rdata got %h want %h", b2.dm_rdata, exp);
        end
      end
      if (b2.if_valid) begin
        valids++;
        exp = (exp_if_q.size() > 0) ? exp_if_q.pop_front() : 16'hxxxx;
        tests++;
        if (b2.if_rdata !== exp) begin
          fails++;
          $display("FAIL starve_if_rdata got %h want %h", b2.if_rdata, exp);
        end
      end
      if (grants >= 6) begin
        @(posedge clk); #1;
        b2.dm_req = 1'b0; b2.if_req = 1'b0;
      end
    end
    b2.dm_req = 1'b0; b2.if_req = 1'b0;
    tests++;
    if (first_if !== exp_first) begin
      fails++;
      $display("FAIL starve_first_fetch got grant #%0d want #%0d (0 = never)", first_if, exp_first);
    end
    tests++;
    if (grants !== 6 || valids !== 6) begin
      fails++;
      $display("FAIL starve_count got %0d grants %0d valids want 6 6", grants, valids);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic seen;
    logic [15:0] exp;
    @(posedge clk); #1;
    b2.if_req = 1'b1; b2.if_addr = 16'h0060;
    exp_if_q.push_back(mem_model(16'h0060));
    @(negedge clk); @(negedge clk);
    @(posedge clk); #1;
    b2.if_req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({b2.if_gnt, b2.if_valid, b2.dm_gnt, b2.dm_valid, b2.mem_en, b2.mem_we, busy_a} !== 7'b0) begin
      fails++;
      $display("FAIL rstmid_ctrl got %b want 0000000",
               {b2.if_gnt, b2.if_valid, b2.dm_gnt, b2.dm_valid, b2.mem_en, b2.mem_we, busy_a});
    end
    tests++;
    if ({b2.mem_addr, b2.mem_wdata, b2.if_rdata, b2.dm_rdata} !== 64'h0) begin
      fails++;
      $display("FAIL rstmid_data got %h want 0", {b2.mem_addr, b2.mem_wdata, b2.if_rdata, b2.dm_rdata});
    end
    exp_if_q.delete();
    exp_dm_q.delete();
    dm_rd_model = 16'h0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (b2.if_valid || b2.dm_valid || b2.mem_en || busy_a) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_dropped got activity=%b want 0", seen);
    end
    @(posedge clk); #1;
    b2.if_req = 1'b1; b2.if_addr = 16'h0070;
    exp_if_q.push_back(mem_model(16'h0070));
    for (int i = 0; i < 10 && !b2.if_gnt; i++) @(negedge clk);
    @(posedge clk); #1;
    b2.if_req = 1'b0;
    wait_valid(20, cyc);
    exp = (exp_if_q.size() > 0) ? exp_if_q.pop_front() : 16'hxxxx;
    tests++;
    if (cyc !== LAT_A || b2.if_valid !== 1'b1 || b2.if_rdata !== exp) begin
      fails++;
      $display("FAIL rstmid_new_fetch got cyc=%0d v=%b rdata=%h want %0d 1 %h",
               cyc, b2.if_valid, b2.if_rdata, LAT_A, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [15:0] a_tbl [3];
    logic [15:0] exp;
    logic s_ig;
    int k = 1;
    int last_v = -1;
    a_tbl[0] = 16'h0100; a_tbl[1] = 16'h0104; a_tbl[2] = 16'h0108;
    @(posedge clk); #1;
    b1.if_req = 1'b1; b1.if_addr = a_tbl[0];
    exp_if_q.push_back(mem_model(a_tbl[0]));
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      s_ig = b1.if_gnt;
      tests++;
      if (busy_b !== (c < 9 && c % 3 != 0)) begin
        fails++;
        $display("FAIL b2b_busy cycle %0d got %b want %b", c, busy_b, (c < 9 && c % 3 != 0));
      end
      tests++;
      if (b1.mem_en !== (c < 9 && c % 3 == 1) || b1.if_valid !== (c < 9 && c % 3 == 2)) begin
        fails++;
        $display("FAIL b2b_pulses cycle %0d got en=%b v=%b want %b %b", c, b1.mem_en, b1.if_valid,
                 (c < 9 && c % 3 == 1), (c < 9 && c % 3 == 2));
      end
      if (b1.if_valid) begin
        last_v = c;
        exp = (exp_if_q.size() > 0) ? exp_if_q.pop_front() : 16'hxxxx;
        tests++;
        if (b1.if_rdata !== exp) begin
          fails++;
          $display("FAIL b2b_rdata got %h want %h", b1.if_rdata, exp);
        end
      end
      @(posedge clk); #1;
      if (s_ig) begin
        if (k < 3) begin
          b1.if_addr = a_tbl[k];
          exp_if_q.push_back(mem_model(a_tbl[k]));
          k++;
        end else begin
          b1.if_req = 1'b0;
        end
      end
    end
    tests++;
    if (last_v !== 8) begin
      fails++;
      $display("FAIL b2b_length got last valid in cycle %0d want 8", last_v);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    b2.if_req = 1'b0; b2.if_addr = '0; b2.dm_req = 1'b0; b2.dm_we = 1'b0; b2.dm_addr = '0; b2.dm_wdata = '0;
    b1.if_req = 1'b0; b1.if_addr = '0; b1.dm_req = 1'b0; b1.dm_we = 1'b0; b1.dm_addr = '0; b1.dm_wdata = '0;
    test_reset();
    test_fetch();
    test_write();
    test_simultaneous();
    test_starvation();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
